// File: rtl/gb_audio_pkg.sv
// Shared constants and types for the Game Boy audio mixer / PDM DAC path.
package gb_audio_pkg;

  localparam int FULL_SCALE = 480;
  localparam int SAMPLE_W   = 9;
  localparam int CH_W       = 4;
  localparam int NUM_CH     = 4;
  localparam int SUM_W      = 6;
  localparam int ERR_W      = 10;

  // NR51: right-side enables in the low nibble, left-side in the high nibble
  localparam int NR51_R_LSB = 0;
  localparam int NR51_L_LSB = 4;

  typedef logic [NUM_CH-1:0][CH_W-1:0] ch_bundle_t;

endpackage

// File: rtl/gb_mixer_dac_if.sv
// Mixer register/sample bus. Optional ch_mute exists only with MIXER_CH_MUTE_EN.
interface gb_mixer_dac_if;
  import gb_audio_pkg::*;

  logic                     master_en;
  logic [NUM_CH*CH_W-1:0]   ch_sig;
  logic [NUM_CH-1:0]        ch_dac_en;
  logic [7:0]               nr51;
  logic [2:0]               vol_l;
  logic [2:0]               vol_r;
`ifdef MIXER_CH_MUTE_EN
  logic [NUM_CH-1:0]        ch_mute;
`endif
  logic [SAMPLE_W-1:0]      sample_l;
  logic [SAMPLE_W-1:0]      sample_r;
  logic                     sample_valid;
  logic                     pdm_l;
  logic                     pdm_r;

  modport master (
    output master_en, ch_sig, ch_dac_en, nr51, vol_l, vol_r,
`ifdef MIXER_CH_MUTE_EN
    output ch_mute,
`endif
    input  sample_l, sample_r, sample_valid, pdm_l, pdm_r
  );

  modport slave (
    input  master_en, ch_sig, ch_dac_en, nr51, vol_l, vol_r,
`ifdef MIXER_CH_MUTE_EN
    input  ch_mute,
`endif
    output sample_l, sample_r, sample_valid, pdm_l, pdm_r
  );

endinterface

// File: rtl/gb_sigma_delta.sv
// First-order sigma-delta modulator: ones density equals i_sample / FS.
module gb_sigma_delta
  import gb_audio_pkg::*;
#(
  parameter int FS = FULL_SCALE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_en,
  input  logic                i_clr,
  input  logic [SAMPLE_W-1:0] i_sample,
  output logic                o_pdm
);

  logic [ERR_W-1:0] r_err;
  logic             r_pdm;
  logic [ERR_W-1:0] w_sum;

  // r_err < FS and i_sample <= FS, so the sum never exceeds 2*FS-1
  assign w_sum = r_err + ERR_W'(i_sample);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= '0;
      r_pdm <= 1'b0;
    end else if (i_clr) begin
      r_err <= '0;
      r_pdm <= 1'b0;
    end else if (i_en) begin
      if (w_sum >= ERR_W'(FS)) begin
        r_pdm <= 1'b1;
        r_err <= w_sum - ERR_W'(FS);
      end else begin
        r_pdm <= 1'b0;
        r_err <= w_sum;
      end
    end
  end

  assign o_pdm = r_pdm;

endmodule

// File: rtl/gb_mixer_dac.sv
// Four-channel mixer with NR51 panning, NR50 volume and per-side PDM output.
// Optional debug muting is built when MIXER_CH_MUTE_EN is defined.
module gb_mixer_dac
  import gb_audio_pkg::*;
#(
  parameter int SAMPLE_DIV = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  gb_mixer_dac_if.slave  bus
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);

  logic [DIV_W-1:0]    r_div;
  logic                w_tick;
  ch_bundle_t          w_ch_in;
  ch_bundle_t          w_ch_masked;
  logic [NUM_CH-1:0]   w_ch_en;

  ch_bundle_t          r_a_ch;
  logic [7:0]          r_a_nr51;
  logic [2:0]          r_a_vol_l, r_a_vol_r;
  logic                r_a_vld;

  logic [SUM_W-1:0]    w_sum_l, w_sum_r;
  logic [SUM_W-1:0]    r_b_sum_l, r_b_sum_r;
  logic [2:0]          r_b_vol_l, r_b_vol_r;
  logic                r_b_vld;

  logic [SAMPLE_W-1:0] w_mul_l, w_mul_r;
  logic [SAMPLE_W-1:0] r_sample_l, r_sample_r;
  logic                r_c_vld;

  assign w_tick = (r_div == DIV_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               r_div <= '0;
    else if (!bus.master_en)  r_div <= '0;
    else if (w_tick)          r_div <= '0;
    else                      r_div <= r_div + 1'b1;
  end

  assign w_ch_in = ch_bundle_t'(bus.ch_sig);
`ifdef MIXER_CH_MUTE_EN
  assign w_ch_en = bus.ch_dac_en & ~bus.ch_mute;
`else
  assign w_ch_en = bus.ch_dac_en;
`endif

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_mask
    assign w_ch_masked[gi] = w_ch_en[gi] ? w_ch_in[gi] : '0;
  end

  always_comb begin
    w_sum_l = '0;
    w_sum_r = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_a_nr51[NR51_L_LSB + i]) w_sum_l = w_sum_l + SUM_W'(r_a_ch[i]);
      if (r_a_nr51[NR51_R_LSB + i]) w_sum_r = w_sum_r + SUM_W'(r_a_ch[i]);
    end
  end

  // Widen both operands first so the product (max 60*8) is not truncated
  assign w_mul_l = SAMPLE_W'(r_b_sum_l) * (SAMPLE_W'(r_b_vol_l) + SAMPLE_W'(1));
  assign w_mul_r = SAMPLE_W'(r_b_sum_r) * (SAMPLE_W'(r_b_vol_r) + SAMPLE_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || !bus.master_en) begin
      r_a_ch     <= '0;
      r_a_nr51   <= '0;
      r_a_vol_l  <= '0;
      r_a_vol_r  <= '0;
      r_a_vld    <= 1'b0;
      r_b_sum_l  <= '0;
      r_b_sum_r  <= '0;
      r_b_vol_l  <= '0;
      r_b_vol_r  <= '0;
      r_b_vld    <= 1'b0;
      r_sample_l <= '0;
      r_sample_r <= '0;
      r_c_vld    <= 1'b0;
    end else begin
      r_a_vld <= w_tick;
      if (w_tick) begin
        r_a_ch    <= w_ch_masked;
        r_a_nr51  <= bus.nr51;
        r_a_vol_l <= bus.vol_l;
        r_a_vol_r <= bus.vol_r;
      end
      r_b_vld <= r_a_vld;
      if (r_a_vld) begin
        r_b_sum_l <= w_sum_l;
        r_b_sum_r <= w_sum_r;
        r_b_vol_l <= r_a_vol_l;
        r_b_vol_r <= r_a_vol_r;
      end
      r_c_vld <= r_b_vld;
      if (r_b_vld) begin
        r_sample_l <= w_mul_l;
        r_sample_r <= w_mul_r;
      end
    end
  end

  assign bus.sample_l     = r_sample_l;
  assign bus.sample_r     = r_sample_r;
  assign bus.sample_valid = r_c_vld;

  gb_sigma_delta #(.FS(FULL_SCALE)) u_sd_l (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (bus.master_en),
    .i_clr    (~bus.master_en),
    .i_sample (r_sample_l),
    .o_pdm    (bus.pdm_l)
  );

  gb_sigma_delta #(.FS(FULL_SCALE)) u_sd_r (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (bus.master_en),
    .i_clr    (~bus.master_en),
    .i_sample (r_sample_r),
    .o_pdm    (bus.pdm_r)
  );

endmodule

// File: tb/tb_gb_mixer_dac.sv
// Self-checking bench for gb_mixer_dac; mute scenario built with MIXER_CH_MUTE_EN.
module tb_gb_mixer_dac;
  import gb_audio_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gb_mixer_dac_if u_if ();

  gb_mixer_dac #(.SAMPLE_DIV(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] cfg_ch;
  logic [3:0]  cfg_en;
  logic [7:0]  cfg_nr51;
  logic [2:0]  cfg_vl, cfg_vr;
  logic [3:0]  cfg_mute;

  // Reference: sum the panned, enabled, unmuted channels, then scale by vol+1
  function automatic int model_sample(input logic [15:0] ch, input logic [3:0] en,
                                      input logic [3:0] pan, input logic [2:0] vol,
                                      input logic [3:0] mute);
    int s = 0;
    for (int i = 0; i < 4; i++)
      if (en[i] && pan[i] && !mute[i]) s += int'(ch[4*i +: 4]);
    return s * (int'(vol) + 1);
  endfunction

  function automatic int exp_l();
    return model_sample(cfg_ch, cfg_en, cfg_nr51[7:4], cfg_vl, cfg_mute);
  endfunction

  function automatic int exp_r();
    return model_sample(cfg_ch, cfg_en, cfg_nr51[3:0], cfg_vr, cfg_mute);
  endfunction

  // Ideal modulator starting from zero error: bit n is the step in floor(n*s/FS)
  function automatic int ideal_pdm(input int n, input int s);
    return (n * s) / FULL_SCALE - ((n - 1) * s) / FULL_SCALE;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic apply();
    u_if.ch_sig    = cfg_ch;
    u_if.ch_dac_en = cfg_en;
    u_if.nr51      = cfg_nr51;
    u_if.vol_l     = cfg_vl;
    u_if.vol_r     = cfg_vr;
`ifdef MIXER_CH_MUTE_EN
    u_if.ch_mute   = cfg_mute;
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns edges waited until sample_valid (limit+1 on timeout) and whether samples held meanwhile
  task automatic wait_valid(input int limit, output int cyc, output bit held);
    logic [8:0] l0, r0;
    l0 = u_if.sample_l;
    r0 = u_if.sample_r;
    held = 1'b1;
    for (cyc = 1; cyc <= limit; cyc++) begin
      step();
      if (u_if.sample_valid) return;
      if (u_if.sample_l !== l0 || u_if.sample_r !== r0) held = 1'b0;
    end
  endtask

  // Sync to a sample, load cfg, and check the next sample period
  task automatic next_sample(input string tag);
    int cyc;
    bit held;
    wait_valid(70, cyc, held);
    check({tag, "_sync"}, cyc <= 70, 1);
    apply();
    wait_valid(70, cyc, held);
    check({tag, "_period"}, cyc, 64);
    check({tag, "_hold"}, held, 1);
    check({tag, "_sample_l"}, u_if.sample_l, exp_l());
    check({tag, "_sample_r"}, u_if.sample_r, exp_r());
    step();
    check({tag, "_valid_pulse"}, u_if.sample_valid, 0);
    $display("txn %s: ch=%h en=%b nr51=%h vol=%0d/%0d -> L=%0d R=%0d",
             tag, cfg_ch, cfg_en, cfg_nr51, cfg_vl, cfg_vr, u_if.sample_l, u_if.sample_r);
  endtask

  task automatic pattern_check(input string tag);
    int sl, sr;
    sl = exp_l();
    sr = exp_r();
    for (int n = 1; n <= 8; n++) begin
      step();
      check({tag, "_pdm_l"}, u_if.pdm_l, ideal_pdm(n, sl));
      check({tag, "_pdm_r"}, u_if.pdm_r, ideal_pdm(n, sr));
    end
  endtask

  task automatic count_ones(input int len, output int ones_l, output int ones_r);
    ones_l = 0;
    ones_r = 0;
    for (int i = 0; i < len; i++) begin
      step();
      ones_l += int'(u_if.pdm_l);
      ones_r += int'(u_if.pdm_r);
    end
  endtask

  task automatic set_pan_scale();
    cfg_ch = 16'h000F; cfg_en = 4'hF; cfg_nr51 = 8'h11; cfg_vl = 3'd7; cfg_vr = 3'd0;
    cfg_mute = 4'h0;
  endtask

  initial begin
    int cyc, ol, orr;
    bit held, quiet;

    // Reset state
    rst_n = 1'b0;
    u_if.master_en = 1'b0;
    set_pan_scale();
    apply();
    #12;
    check("rst_sample_l", u_if.sample_l, 0);
    check("rst_sample_r", u_if.sample_r, 0);
    check("rst_valid", u_if.sample_valid, 0);
    check("rst_pdm_l", u_if.pdm_l, 0);
    check("rst_pdm_r", u_if.pdm_r, 0);

    // First sample after release: 63 edges to tick, capture, then two pipeline edges
    @(negedge clk);
    rst_n = 1'b1;
    u_if.master_en = 1'b1;
    wait_valid(80, cyc, held);
    check("first_latency", cyc, 66);
    check("pan_sample_l", u_if.sample_l, exp_l());
    check("pan_sample_r", u_if.sample_r, exp_r());
    check("pan_pdm_at_valid", u_if.pdm_l, 0);
    pattern_check("pan");
    count_ones(480, ol, orr);
    check("pan_density_l", ol, 120);
    check("pan_density_r", orr, 15);

    // Full scale and silence
    cfg_ch = 16'hFFFF; cfg_nr51 = 8'hFF; cfg_vl = 3'd7; cfg_vr = 3'd7;
    next_sample("full");
    count_ones(64, ol, orr);
    check("full_ones_l", ol, 64);
    check("full_ones_r", orr, 64);
    cfg_ch = 16'h0000;
    next_sample("zero");
    count_ones(64, ol, orr);
    check("zero_ones_l", ol, 0);
    check("zero_ones_r", orr, 0);

    // DAC enable masking: ch3 must not contribute
    cfg_ch = {4'($urandom_range(0, 15)), 4'hA, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
    cfg_en = 4'b1011; cfg_nr51 = 8'hFF; cfg_vl = 3'd0; cfg_vr = 3'd0;
    next_sample("dacmask");
    check("dacmask_direct", u_if.sample_l, int'(cfg_ch[3:0]) + int'(cfg_ch[7:4]) + int'(cfg_ch[15:12]));

    // Randomised configurations
    for (int t = 0; t < 8; t++) begin
      cfg_ch = 16'($urandom);
      cfg_en = 4'($urandom);
      cfg_nr51 = 8'($urandom);
      cfg_vl = 3'($urandom);
      cfg_vr = 3'($urandom);
      next_sample($sformatf("rand%0d", t));
    end

`ifdef MIXER_CH_MUTE_EN
    set_pan_scale();
    cfg_ch = 16'h050F;
    cfg_mute = 4'b0001;
    next_sample("mute");
    check("mute_direct_l", u_if.sample_l, 0);
    cfg_mute = 4'b0000;
`endif

    // master_en drop mid-sample, then restart
    set_pan_scale();
    next_sample("pre_off");
    repeat (20) step();
    u_if.master_en = 1'b0;
    step();
    check("off_pdm_l", u_if.pdm_l, 0);
    check("off_pdm_r", u_if.pdm_r, 0);
    check("off_sample_l", u_if.sample_l, 0);
    check("off_sample_r", u_if.sample_r, 0);
    quiet = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (u_if.sample_valid !== 1'b0 || u_if.pdm_l !== 1'b0) quiet = 1'b0;
    end
    check("off_quiet", quiet, 1);
    u_if.master_en = 1'b1;
    wait_valid(80, cyc, held);
    check("restart_latency", cyc, 66);
    check("restart_sample_l", u_if.sample_l, exp_l());
    pattern_check("restart");

    // Asynchronous reset while a sample is in flight
    wait_valid(70, cyc, held);
    check("rstmid_sync", cyc <= 70, 1);
    repeat (63) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_sample_l", u_if.sample_l, 0);
    check("rstmid_sample_r", u_if.sample_r, 0);
    check("rstmid_valid", u_if.sample_valid, 0);
    check("rstmid_pdm_l", u_if.pdm_l, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(80, cyc, held);
    check("rstmid_no_spurious", cyc, 66);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gb_mixer_dac.md
Name: gb_mixer_dac

Overview:
- Downstream of the four sound channels (square1, square2, wave, noise). Consumes each channel's 4-bit `signal` output.
- Applies NR51 panning and NR50 master volume per side to produce a 9-bit left/right sample.
- Converts each side to a 1-bit PDM stream with a first-order sigma-delta modulator.
- The PDM pins drive the board RC filters. The samples are also exported for the software DAC bench model.

Parameters:
- SAMPLE_DIV, 64, clk cycles per mixer sample tick (≥4).
- FULL_SCALE, 480, max scaled sample (4 ch × 15 × 8). Modulator threshold.

Ports:
- clk  in  1  4.194304 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- master_en  in  1  NR52 bit 7. Low = audio off.
- ch_sig  in  16  channel outputs: ch1=[3:0], ch2=[7:4], ch3=[11:8], ch4=[15:12]
- ch_dac_en  in  4  per-channel DAC enable. 0 means the channel contributes 0.
- nr51  in  8  panning: [7:4] left ch4..ch1, [3:0] right ch4..ch1
- vol_l  in  3  NR50[6:4]
- vol_r  in  3  NR50[2:0]
- sample_l  out  9  scaled left sample, 0..480
- sample_r  out  9  scaled right sample
- sample_valid  out  1  one-cycle pulse when sample_l/r update
- pdm_l  out  1  left PDM bit
- pdm_r  out  1  right PDM bit

Behaviour:
- Reset: all outputs 0, divider 0, pipeline registers 0, modulator error accumulators 0.
- Divider:
  - Counts 0..SAMPLE_DIV-1 and wraps.
  - tick = (count == SAMPLE_DIV-1).
- Pipeline, 3 stages, no stalls:
  - Stage A, on the edge with tick=1: capture ch_sig masked by ch_dac_en, plus nr51, vol_l, vol_r. Inputs changing at other times have no effect until the next tick.
  - Stage B, next edge: sum_l = Σ ch_i where nr51[4+i]=1; sum_r likewise with nr51[i]. Each sum is 6 bits, 0..60.
  - Stage C, next edge: sample_l = sum_l × (vol_l+1) and sample_r = sum_r × (vol_r+1), 9 bits, exact, no saturation needed. sample_valid=1 for this cycle only.
  - Latency is 2 clks from the capture edge to sample_valid.
  - sample_l/r hold between updates.
- Modulator, per side, every clk edge:
  - S = E + sample, where E is 10 bits.
  - If S ≥ FULL_SCALE: pdm=1 and E ← S − FULL_SCALE. Otherwise pdm=0 and E ← S.
  - Ones density = sample/FULL_SCALE exactly over FULL_SCALE cycles. sample=0 gives constant 0; sample=480 gives constant 1.
  - The modulator uses the registered sample_l/r value.
- master_en low:
  - Synchronously clears divider, pipeline, samples, E and pdm to 0 on the next edge.
  - sample_valid stays 0.
  - Restart on rise: the divider resumes from 0, so the first tick is SAMPLE_DIV-1 edges later.
- Simultaneous tick and master_en fall: clear wins.
- Reset mid-pipeline: in-flight samples are discarded and no sample_valid is emitted.

Optional Feature:
- MIXER_CH_MUTE_EN:
  - When defined, adds input `ch_mute` (4 bits). Muted channels are masked at stage A, identically to ch_dac_en=0. Intended for debug solo/mute.
  - When undefined, the port is absent and no masking logic is built.

Decomposition:
- Shared package gb_audio_pkg holds:
  - constants FULL_SCALE=480, SAMPLE_W=9, CH_W=4, NUM_CH=4;
  - NR51 bit-index localparams;
  - typedef for the 4×4 channel bundle.
- One natural sub-module, gb_sigma_delta (sample in, pdm out, en/clear), instantiated twice (left, right).

Test Plan:
- Pan and scale: ch1=15, others 0, dac_en=4'b1111, nr51=8'h11, vol_l=7, vol_r=0 → sample_l=120, sample_r=15. pdm_l high exactly 1 of every 4 clks (pattern 0,0,0,1). pdm_r has 15 ones per 480 clks.
- Full scale: all channels 15, nr51=8'hFF, vols=7 → samples=480, pdm_l=pdm_r=1 constant. All channels 0 → pdm constant 0.
- Latency and hold: change ch_sig 1 clk after a tick → no sample change until the next tick. sample_valid asserts exactly 2 clks after the capture edge, once per 64 clks.
- DAC enable masking: ch3=10, dac_en=4'b1011, nr51=8'hFF, vol=0 → samples equal the sum of ch1, ch2 and ch4 only.
- master_en drop mid-sample: pdm goes 0 next edge and sample=0. On re-enable, the first sample_valid occurs 66 clks after master_en rises.
- Reset: assert rst_n=0 asynchronously mid-pipeline → all outputs 0 immediately, no spurious sample_valid after release. With MIXER_CH_MUTE_EN: ch_mute=4'b0001 removes ch1's 120 contribution.
